l1a_long_dly: RTL and testbench

- Programmable long-delay line for single-clock event pulses (L1A, LCT strobes, and similar) where the required latency exceeds a 16-deep shift-register tap.
- Stores target timestamps in a small FIFO rather than shifting every clock. It replays each accepted input pulse as a one-cycle output pulse a programmed number of enabled clocks later.
- Sits in the L1A/data matching path, downstream of the pulse source and upstream of the readout match logic.

---
 rtl/l1a_long_dly_if.sv | 16 +
 rtl/l1a_long_dly.sv | 78 +++++++
 tb/tb_l1a_long_dly.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/l1a_long_dly_if.sv
// Pulse-path bundle for the long-delay line: strobe/delay in, delayed pulse and status out.
interface l1a_long_dly_if #(
    parameter int unsigned CNT_W = 12,
    parameter int unsigned AW    = 4
);
    logic             CE;
    logic [CNT_W-1:0] DLY;
    logic             I;
    logic             O;
    logic             BUSY;
    logic [AW:0]      PEND;
    logic             OVFL;

    modport master (output CE, DLY, I, input O, BUSY, PEND, OVFL);
    modport slave  (input CE, DLY, I, output O, BUSY, PEND, OVFL);
endinterface

// File: rtl/l1a_long_dly.sv
// Long programmable pulse delay: timestamps each accepted pulse into a FIFO and
// replays it when the free-running counter reaches the stored target.
module l1a_long_dly #(
    parameter int unsigned CNT_W = 12,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          CLK,
    input  logic          RST,
    l1a_long_dly_if.slave bus
);

    logic [CNT_W-1:0] tcnt;
    logic [CNT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    wptr;
    logic [AW:0]      pend;
    logic             o_q;
    logic             busy_q;
    logic             ovfl_q;

    logic [CNT_W-1:0] dly_e_c;
    logic [CNT_W-1:0] tgt_c;
    logic             empty_c;
    logic             full_c;
    logic             pop_c;
    logic             push_c;
    logic             drop_c;
    logic [AW:0]      pend_nxt_c;

    // DLY=0 is treated as 1 so a new entry can never match on its own push edge.
    always_comb begin
        dly_e_c    = (bus.DLY == '0) ? CNT_W'(1) : bus.DLY;
        tgt_c      = tcnt + dly_e_c;
        empty_c    = (pend == '0);
        full_c     = (pend == (AW+1)'(DEPTH));
        pop_c      = bus.CE && !empty_c && (mem[rptr] == tcnt);
        push_c     = bus.CE && bus.I && (!full_c || pop_c);
        drop_c     = bus.CE && bus.I && full_c && !pop_c;
        pend_nxt_c = pend;
        case ({push_c, pop_c})
            2'b10:   pend_nxt_c = pend + (AW+1)'(1);
            2'b01:   pend_nxt_c = pend - (AW+1)'(1);
            default: pend_nxt_c = pend;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tcnt   <= '0;
            rptr   <= '0;
            wptr   <= '0;
            pend   <= '0;
            o_q    <= 1'b0;
            busy_q <= 1'b0;
            ovfl_q <= 1'b0;
        end else if (bus.CE) begin
            tcnt   <= tcnt + CNT_W'(1);
            pend   <= pend_nxt_c;
            busy_q <= (pend_nxt_c != '0);
            o_q    <= pop_c;
            if (push_c) wptr <= wptr + AW'(1);
            if (pop_c)  rptr <= rptr + AW'(1);
            if (drop_c) ovfl_q <= 1'b1;
        end
    end

    // Target storage: synchronous write, asynchronous read of the head.
    always_ff @(posedge CLK) begin
        if (!RST && push_c) mem[wptr] <= tgt_c;
    end

    assign bus.O    = o_q;
    assign bus.BUSY = busy_q;
    assign bus.PEND = pend;
    assign bus.OVFL = ovfl_q;

endmodule

// File: tb/tb_l1a_long_dly.sv
// Self-checking bench for l1a_long_dly: directed scenarios plus random traffic
// compared against an absolute-time queue model.
module tb_l1a_long_dly;

    logic CLK;
    logic RST;

    l1a_long_dly_if #(.CNT_W(12), .AW(4)) bus ();

    l1a_long_dly #(.CNT_W(12), .DEPTH(16), .AW(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model: absolute CE-edge index at which each outstanding pulse is due.
    int q[$];
    int kce    = 0;
    bit m_o    = 1'b0;
    bit m_ovfl = 1'b0;

    // Observation helpers for directed checks.
    int o_cnt    = 0;
    int o_edge   = -1;
    int abs_edge = 0;
    int o_abs    = -1;
    int pend_max = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit ce, input bit i, input logic [11:0] dly);
        bit pop;
        int k_this;
        RST     = rst;
        bus.CE  = ce;
        bus.I   = i;
        bus.DLY = dly;
        @(posedge CLK);
        k_this = kce;
        if (rst) begin
            q.delete();
            kce    = 0;
            m_o    = 1'b0;
            m_ovfl = 1'b0;
        end else if (ce) begin
            pop = (q.size() > 0) && (q[0] == kce);
            if (pop) void'(q.pop_front());
            if (i) begin
                if (q.size() < 16) q.push_back(kce + ((dly == 12'd0) ? 1 : int'(dly)));
                else m_ovfl = 1'b1;
            end
            m_o = pop;
            kce++;
        end
        #1;
        check("O",    32'(bus.O),    32'(m_o));
        check("PEND", 32'(bus.PEND), 32'(q.size()));
        check("BUSY", 32'(bus.BUSY), 32'(q.size() != 0));
        check("OVFL", 32'(bus.OVFL), 32'(m_ovfl));
        if (!rst && ce && bus.O) begin
            o_cnt++;
            if (o_edge < 0) o_edge = k_this;
            if (o_abs < 0)  o_abs  = abs_edge;
        end
        if (int'(bus.PEND) > pend_max) pend_max = int'(bus.PEND);
        abs_edge++;
    endtask

    task automatic reset_and_clear();
        step(1'b1, 1'b1, 1'b0, 12'd0);
        o_cnt    = 0;
        o_edge   = -1;
        o_abs    = -1;
        abs_edge = 0;
        pend_max = 0;
    endtask

    task automatic idle(input int n, input logic [11:0] dly);
        for (int j = 0; j < n; j++) step(1'b0, 1'b1, 1'b0, dly);
    endtask

    initial begin
        RST     = 1'b1;
        bus.CE  = 1'b0;
        bus.I   = 1'b0;
        bus.DLY = '0;

        // Reset state, then a single DLY=4 pulse at edge 10.
        reset_and_clear();
        check("rst_O",    32'(bus.O),    32'd0);
        check("rst_PEND", 32'(bus.PEND), 32'd0);
        idle(10, 12'd4);
        step(1'b0, 1'b1, 1'b1, 12'd4);
        check("d4_pend_after_push", 32'(bus.PEND), 32'd1);
        idle(10, 12'd4);
        check("d4_o_edge", 32'(o_edge), 32'd14);
        check("d4_o_cnt",  32'(o_cnt),  32'd1);

        // DLY=0 behaves as DLY=1.
        reset_and_clear();
        idle(5, 12'd0);
        step(1'b0, 1'b1, 1'b1, 12'd0);
        idle(5, 12'd0);
        check("d0_o_edge", 32'(o_edge), 32'd6);
        check("d0_o_cnt",  32'(o_cnt),  32'd1);

        // Maximum delay across the counter wrap.
        reset_and_clear();
        step(1'b0, 1'b1, 1'b1, 12'd4095);
        idle(4100, 12'd4095);
        check("dmax_o_edge", 32'(o_edge), 32'd4095);
        check("dmax_o_cnt",  32'(o_cnt),  32'd1);

        // Overflow: 17 back-to-back pulses, the last dropped.
        reset_and_clear();
        for (int j = 0; j < 17; j++) step(1'b0, 1'b1, 1'b1, 12'd100);
        check("ovf_flag", 32'(bus.OVFL), 32'd1);
        idle(130, 12'd100);
        check("ovf_o_cnt",    32'(o_cnt),    32'd16);
        check("ovf_o_edge",   32'(o_edge),   32'd100);
        check("ovf_pend_max", 32'(pend_max), 32'd16);
        check("ovf_sticky",   32'(bus.OVFL), 32'd1);

        // Full FIFO with push and pop on the same edge.
        reset_and_clear();
        for (int j = 0; j < 16; j++) step(1'b0, 1'b1, 1'b1, 12'd20);
        idle(4, 12'd20);
        step(1'b0, 1'b1, 1'b1, 12'd20);
        check("fullpp_pend", 32'(bus.PEND), 32'd16);
        check("fullpp_ovfl", 32'(bus.OVFL), 32'd0);
        idle(30, 12'd20);
        check("fullpp_o_cnt", 32'(o_cnt), 32'd17);

        // CE stall during the delay and during an O=1 cycle.
        reset_and_clear();
        step(1'b0, 1'b1, 1'b1, 12'd10);
        idle(2, 12'd10);
        for (int j = 0; j < 5; j++) step(1'b0, 1'b0, 1'b0, 12'd10);
        while (abs_edge < 16) step(1'b0, 1'b1, 1'b0, 12'd10);
        check("ce_o_abs", 32'(o_abs), 32'd15);
        check("ce_o_now", 32'(bus.O), 32'd1);
        step(1'b0, 1'b0, 1'b1, 12'd10);
        check("ce_o_held", 32'(bus.O), 32'd1);
        step(1'b0, 1'b1, 1'b0, 12'd10);
        check("ce_o_drop", 32'(bus.O), 32'd0);

        // Reset discards in-flight pulses; a fresh pulse still works.
        reset_and_clear();
        step(1'b0, 1'b1, 1'b1, 12'd50);
        step(1'b0, 1'b1, 1'b0, 12'd50);
        step(1'b0, 1'b1, 1'b1, 12'd50);
        idle(27, 12'd50);
        reset_and_clear();
        check("rr_pend", 32'(bus.PEND), 32'd0);
        step(1'b0, 1'b1, 1'b1, 12'd3);
        idle(80, 12'd3);
        check("rr_o_cnt",  32'(o_cnt),  32'd1);
        check("rr_o_edge", 32'(o_edge), 32'd3);

        // Random traffic; DLY only changes while nothing is outstanding.
        begin
            logic [11:0] rdly;
            rdly = 12'd7;
            reset_and_clear();
            for (int n = 0; n < 4000; n++) begin
                bit r_rst, r_ce, r_i;
                if (q.size() == 0 && $urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 7) == 0) rdly = 12'($urandom_range(200, 300));
                    else                           rdly = 12'($urandom_range(0, 40));
                end
                r_rst = ($urandom_range(0, 999) < 3);
                r_ce  = ($urandom_range(0, 9) < 8);
                r_i   = ($urandom_range(0, 9) < 4);
                step(r_rst, r_ce, r_i, rdly);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
